// File: rtl/z80_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : z80_trace_pkg
//  Description : Shared types and defaults for the Z80 bus tracer: record
//                kind encoding, the trace record layout and the default
//                FIFO depth / timestamp width.
//  Revision    : 1.0 - initial release
// ============================================================================
package z80_trace_pkg;

    localparam int c_DEPTH_DEFAULT   = 16;
    localparam int c_STAMP_W_DEFAULT = 16;

    // Bus-cycle classification; codes 6 and 7 are never produced
    typedef enum logic [2:0] {
        KIND_M1_FETCH = 3'd0,
        KIND_MEM_RD   = 3'd1,
        KIND_MEM_WR   = 3'd2,
        KIND_IO_RD    = 3'd3,
        KIND_IO_WR    = 3'd4,
        KIND_INT_ACK  = 3'd5
    } trace_kind_e;

    // One captured bus cycle, at the default timestamp width
    typedef struct packed {
        trace_kind_e                  kind;
        logic [15:0]                  addr;
        logic [7:0]                   data;
        logic [c_STAMP_W_DEFAULT-1:0] stamp;
    } trace_rec_t;

endpackage
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : trace_fifo
//  Description : Single-clock FIFO holding packed trace records. Occupancy
//                is a registered count; full/empty derive from it. A push
//                while full is accepted only when a pop happens on the same
//                edge. clear outranks push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_AW = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    // Empty FIFO presents all-zero fields rather than stale storage
    assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; the array itself needs no reset
    always_ff @(posedge clk) begin
        if (w_push_ok && !clear) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping, with clear overriding traffic
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/z80_bus_tracer.sv
`default_nettype none
// ============================================================================
//  Module      : z80_bus_tracer
//  Description : Watches the Z80 bus strobes, classifies each memory / IO /
//                interrupt-acknowledge cycle, and queues {kind, addr, data,
//                timestamp} records for a valid/ready consumer. Refresh
//                cycles are ignored; overflowing records are counted.
//  Revision    : 1.0 - initial release
// ============================================================================
module z80_bus_tracer
    import z80_trace_pkg::*;
#(
    parameter int DEPTH   = c_DEPTH_DEFAULT,
    parameter int STAMP_W = c_STAMP_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cen,
    input  logic                     m1_n,
    input  logic                     mreq_n,
    input  logic                     iorq_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    input  logic                     rfsh_n,
    input  logic [15:0]              A,
    input  logic [7:0]               di,
    input  logic [7:0]               dout,
    input  logic                     clear,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [2:0]               rec_kind,
    output logic [15:0]              rec_addr,
    output logic [7:0]               rec_data,
    output logic [STAMP_W-1:0]       rec_stamp,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic [7:0]               drops
);

    localparam int c_REC_W = 3 + 16 + 8 + STAMP_W;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    state_e               r_state;
    logic                 r_armed;
    logic [STAMP_W-1:0]   r_stamp;
    logic [STAMP_W-1:0]   r_lat_stamp;
    trace_kind_e          r_kind;
    logic [15:0]          r_addr;
    logic [7:0]           r_data;
    logic                 r_overflow;
    logic [7:0]           r_drops;

    logic                 w_strobe;
    logic                 w_start;
    logic                 w_end;
    trace_kind_e          w_start_kind;
    trace_kind_e          w_kind_cur;
    logic                 w_cap_di;
    logic                 w_cap_do;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;
    logic [c_REC_W-1:0]   w_head;

    assign w_strobe = ~mreq_n | ~iorq_n;
    // r_armed blocks a strobe still held low across reset from opening a cycle
    assign w_start  = cen & (r_state == ST_IDLE) & w_strobe & rfsh_n & r_armed;
    assign w_end    = cen & (r_state == ST_ACTIVE) & ~w_strobe;

    // Classify a cycle from the strobes seen on its opening edge
    always_comb begin
        w_start_kind = KIND_MEM_RD;
        if (!m1_n && !mreq_n) begin
            w_start_kind = KIND_M1_FETCH;
        end else if (!m1_n && !iorq_n) begin
            w_start_kind = KIND_INT_ACK;
        end else if (!mreq_n) begin
            w_start_kind = wr_n ? KIND_MEM_RD : KIND_MEM_WR;
        end else begin
            w_start_kind = wr_n ? KIND_IO_RD : KIND_IO_WR;
        end
    end

    // Interrupt acknowledge has no rd_n strobe but still returns a vector on di
    assign w_kind_cur = (r_state == ST_IDLE) ? w_start_kind : r_kind;
    assign w_cap_di   = ~rd_n | (w_kind_cur == KIND_INT_ACK);
    assign w_cap_do   = ~wr_n;

    // Cycle tracker: latch address/stamp/kind on entry, follow data until release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_kind      <= KIND_M1_FETCH;
            r_addr      <= '0;
            r_data      <= '0;
            r_lat_stamp <= '0;
        end else if (cen) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state     <= ST_ACTIVE;
                        r_kind      <= w_start_kind;
                        r_addr      <= A;
                        r_lat_stamp <= r_stamp;
                        r_data      <= w_cap_di ? di : (w_cap_do ? dout : 8'h00);
                    end
                end
                ST_ACTIVE: begin
                    if (w_end) begin
                        r_state <= ST_IDLE;
                    end else begin
                        if (!wr_n && r_kind == KIND_MEM_RD) begin
                            r_kind <= KIND_MEM_WR;
                        end else if (!wr_n && r_kind == KIND_IO_RD) begin
                            r_kind <= KIND_IO_WR;
                        end
                        if (w_cap_di) begin
                            r_data <= di;
                        end else if (w_cap_do) begin
                            r_data <= dout;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Arm once both strobes have been seen released after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_armed <= 1'b0;
        end else if (cen && !w_strobe) begin
            r_armed <= 1'b1;
        end
    end

    // Free-running timestamp, wraps silently; clear does not touch it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stamp <= '0;
        end else if (cen) begin
            r_stamp <= r_stamp + STAMP_W'(1);
        end
    end

    assign w_pop  = rec_valid & rec_ready;
    assign w_drop = w_end & w_full & ~w_pop;

    // Sticky overflow and saturating drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else if (clear) begin
            r_overflow <= 1'b0;
            r_drops    <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drops != 8'hFF) begin
                r_drops <= r_drops + 8'd1;
            end
        end
    end

    trace_fifo #(
        .WIDTH (c_REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .push  (w_end),
        .pop   (w_pop),
        .wdata ({r_kind, r_addr, r_data, r_lat_stamp}),
        .rdata (w_head),
        .count (fifo_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign rec_valid = ~w_empty;
    assign rec_kind  = w_head[c_REC_W-1 -: 3];
    assign rec_addr  = w_head[STAMP_W+8 +: 16];
    assign rec_data  = w_head[STAMP_W +: 8];
    assign rec_stamp = w_head[STAMP_W-1:0];
    assign overflow  = r_overflow;
    assign drops     = r_drops;

endmodule
`default_nettype wire

// File: tb/tb_z80_bus_tracer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z80_bus_tracer
//  Description : Self-checking bench for z80_bus_tracer. Stimulus tasks
//                describe whole bus cycles and queue the record each one
//                should produce; a monitor pops and compares on every
//                accepted handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_z80_bus_tracer;
    import z80_trace_pkg::*;

    localparam int DEPTH   = 16;
    localparam int STAMP_W = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 cen = 1'b1;
    logic                 m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
    logic                 rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
    logic [15:0]          A = '0;
    logic [7:0]           di = '0, dout = '0;
    logic                 clear = 1'b0;
    logic                 rec_ready = 1'b0;
    logic                 rec_valid;
    logic [2:0]           rec_kind;
    logic [15:0]          rec_addr;
    logic [7:0]           rec_data;
    logic [STAMP_W-1:0]   rec_stamp;
    logic [4:0]           fifo_count;
    logic                 overflow;
    logic [7:0]           drops;

    z80_bus_tracer #(.DEPTH(DEPTH), .STAMP_W(STAMP_W)) dut (
        .clk(clk), .reset(reset), .cen(cen),
        .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
        .A(A), .di(di), .dout(dout), .clear(clear),
        .rec_valid(rec_valid), .rec_ready(rec_ready),
        .rec_kind(rec_kind), .rec_addr(rec_addr), .rec_data(rec_data),
        .rec_stamp(rec_stamp), .fifo_count(fifo_count),
        .overflow(overflow), .drops(drops)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    trace_rec_t exp_q[$];
    int         cen_edges;
    int         m_drops = 0;
    bit         m_ovf = 1'b0;
    bit         rand_cen = 1'b0;
    bit         rand_ready = 1'b0;
    bit         valid_before_exit;

    // Reference time base: number of enabled clock edges since reset
    always @(posedge clk or posedge reset) begin
        if (reset) cen_edges <= 0;
        else if (cen) cen_edges <= cen_edges + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every accepted handshake must match the oldest expected record
    always @(negedge clk) begin
        trace_rec_t e;
        if (!reset && !clear && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_record: got kind=%0d addr=%h data=%h, required none",
                         rec_kind, rec_addr, rec_data);
            end else begin
                e = exp_q.pop_front();
                check("rec_kind",  32'(rec_kind),  32'(e.kind));
                check("rec_addr",  32'(rec_addr),  32'(e.addr));
                check("rec_data",  32'(rec_data),  32'(e.data));
                check("rec_stamp", 32'(rec_stamp), 32'(e.stamp));
            end
        end
    end

    // Advance until n edges have been sampled with cen=1
    task automatic sample(input int n);
        int got = 0;
        bit c;
        while (got < n) begin
            cen = rand_cen ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rand_ready) rec_ready = 1'($urandom_range(0, 1));
            c = cen;
            @(posedge clk);
            #1;
            if (c) got++;
        end
    endtask

    // One complete bus cycle of kind k; queues the record it should yield
    task automatic bus_cycle(input int k, input logic [15:0] addr, input logic [7:0] data,
                             input bit force_ready);
        trace_rec_t e;
        int  st;
        bit  c, drop, pop_now;
        A  = addr;
        st = cen_edges;
        case (k)
            0:       begin m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; end
            1:       begin mreq_n = 1'b0; rd_n = 1'b0; end
            2:       begin mreq_n = 1'b0; end
            3:       begin iorq_n = 1'b0; rd_n = 1'b0; end
            4:       begin iorq_n = 1'b0; end
            default: begin m1_n = 1'b0; iorq_n = 1'b0; end
        endcase
        di   = 8'($urandom);
        dout = 8'($urandom);
        sample(1);
        if (k == 2 || k == 4) begin
            wr_n = 1'b0;
            dout = data;
        end else begin
            di = data;
        end
        sample(1);
        m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        do begin
            cen = rand_cen ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rand_ready) rec_ready = 1'($urandom_range(0, 1));
            if (force_ready) rec_ready = 1'b1;
            c       = cen;
            pop_now = rec_ready && (exp_q.size() != 0);
            drop    = (exp_q.size() >= DEPTH) && !pop_now;
            valid_before_exit = rec_valid;
            @(posedge clk);
            #1;
        end while (!c);
        if (force_ready) rec_ready = 1'b0;
        e.kind  = trace_kind_e'(3'(k));
        e.addr  = addr;
        e.data  = data;
        e.stamp = 16'(st);
        if (drop) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
        end else begin
            exp_q.push_back(e);
        end
    endtask

    // Empty the FIFO through the monitor, with cen low to show pops still work
    task automatic drain();
        int n = 0;
        rand_cen = 1'b0;
        rand_ready = 1'b0;
        cen = 1'b0;
        rec_ready = 1'b1;
        while ((fifo_count != 0 || exp_q.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        rec_ready = 1'b0;
        cen = 1'b1;
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got count %0d, required 0", fifo_count);
        end
        check("drain_count", 32'(fifo_count), 32'(exp_q.size()));
    endtask

    initial begin
        logic [15:0] first_addr;
        int k;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(rec_valid), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_ovf",   32'(overflow), 0);
        check("rst_drops", 32'(drops), 0);
        check("rst_fields", {rec_kind, rec_addr, rec_data}, 0);
        check("rst_stamp", 32'(rec_stamp), 0);
        reset = 1'b0;
        sample(2);

        // Opcode fetch followed by a refresh cycle
        bus_cycle(0, 16'h0000, 8'hFD, 1'b0);
        rfsh_n = 1'b0; mreq_n = 1'b0; A = 16'h0042;
        sample(2);
        mreq_n = 1'b1;
        sample(1);
        rfsh_n = 1'b1;
        sample(1);
        check("m1_count", 32'(fifo_count), 32'(exp_q.size()));
        drain();

        // Memory write with one-clock record latency
        bus_cycle(2, 16'hE545, 8'h3C, 1'b0);
        check("wr_valid_before", 32'(valid_before_exit), 0);
        check("wr_valid_after",  32'(rec_valid), 1);
        drain();

        // IO write then IO read, then interrupt ack and plain read
        bus_cycle(4, 16'h1010, 8'h55, 1'b0);
        bus_cycle(3, 16'h1020, 8'hAA, 1'b0);
        bus_cycle(5, 16'h00FF, 8'hE7, 1'b0);
        bus_cycle(1, 16'h8001, 8'h12, 1'b0);
        check("mixed_count", 32'(fifo_count), 32'(exp_q.size()));
        drain();

        // Randomized cycles with random clock enable and back-pressure
        rand_cen = 1'b1;
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 5);
            bus_cycle(k, 16'($urandom), 8'($urandom), 1'b0);
            sample($urandom_range(0, 2));
        end
        drain();

        // Overflow: 18 reads with no consumer
        first_addr = 16'h4000;
        for (int i = 0; i < 18; i++) begin
            bus_cycle(1, first_addr + 16'(i), 8'(i + 8'h30), 1'b0);
        end
        check("ovf_count", 32'(fifo_count), 16);
        check("ovf_flag",  32'(overflow), 32'(m_ovf));
        check("ovf_drops", 32'(drops), 32'(m_drops));
        check("ovf_head",  32'(rec_addr), 32'(first_addr));

        // Push and pop on the same edge while full
        bus_cycle(2, 16'h5A5A, 8'hC3, 1'b1);
        check("full_pp_count", 32'(fifo_count), 32'(exp_q.size()));
        check("full_pp_drops", 32'(drops), 32'(m_drops));
        drain();

        // Clear with three records queued; overflow is still set from before
        for (int i = 0; i < 3; i++) begin
            bus_cycle(1, 16'h7000 + 16'(i), 8'h77, 1'b0);
        end
        check("pre_clear_ovf", 32'(overflow), 32'(m_ovf));
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        exp_q.delete();
        m_drops = 0;
        m_ovf = 1'b0;
        check("clr_count", 32'(fifo_count), 0);
        check("clr_ovf",   32'(overflow), 0);
        check("clr_drops", 32'(drops), 0);
        sample(3);
        bus_cycle(1, 16'h1234, 8'h9A, 1'b0);
        drain();

        // Reset in the middle of an active memory read
        A = 16'hBEEF; mreq_n = 1'b0; rd_n = 1'b0;
        sample(2);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrst_count", 32'(fifo_count), 0);
        reset = 1'b0;
        sample(3);
        mreq_n = 1'b1; rd_n = 1'b1;
        sample(2);
        check("postrst_valid", 32'(rec_valid), 0);
        bus_cycle(1, 16'hCAFE, 8'h5E, 1'b0);
        check("postrst_count", 32'(fifo_count), 1);
        drain();

        check("final_queue", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
